// File: rtl/seg_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display controller:
// display-word field positions, the glyph table and the blank-segment constant.
package seg_display_pkg;

  // Display word layout: [6] blink, [5] enable, [4:1] glyph code, [0] DP
  localparam int WORD_W    = 7;
  localparam int BLINK_POS = 6;
  localparam int EN_POS    = 5;
  localparam int CODE_HI   = 4;
  localparam int CODE_LO   = 1;
  localparam int DP_POS    = 0;

  // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by glyph code.
  // Codes 0-9 are decimal digits, 10-15 are A, b, C, d, E, F.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // Active-high pattern with every segment dark
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph decoder: 4-bit code to active-high {g,f,e,d,c,b,a}.
module seg7_glyph_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  assign seg = GLYPHS[code];

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment display controller. A per-digit register file is
// written from the system side; a free-running scan timer selects one digit
// per slot and drives registered anode, segment and DP outputs with per-digit
// enable/blink and global PWM brightness.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_LOG2  = 17,
  parameter int BLINK_LOG2 = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           W,
  input  logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] WADD,
  input  logic [6:0]                                     DIN,
  input  logic [3:0]                                     bright,
  output logic [NUM_DIGITS-1:0]                          E,
  output logic [6:0]                                     segOut,
  output logic                                           DP
);

  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  // Inactive level of each output after polarity is applied
  localparam logic [NUM_DIGITS-1:0] E_IDLE   = {NUM_DIGITS{POL}};
  localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ {7{POL}};

  logic [WORD_W-1:0]   words [NUM_DIGITS];
  logic [SCAN_LOG2-1:0] slot_cnt;
  logic [AW-1:0]        idx;
  logic [BLINK_LOG2:0]  frame_cnt;

  logic                 slot_wrap;
  logic                 idx_wrap;
  logic [WORD_W-1:0]    cur_word;
  logic [3:0]           phase;
  logic                 blink_ph;
  logic                 lit_p0;
  logic [6:0]           glyph_p0;
  logic [NUM_DIGITS-1:0] e_p0;
  logic [6:0]           seg_p0;
  logic                 dp_p0;

  // Register file: out-of-range addresses are ignored, reset blanks all digits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) words[i] <= '0;
    end else if (W && (int'(WADD) < NUM_DIGITS)) begin
      words[WADD] <= DIN;
    end
  end

  assign slot_wrap = &slot_cnt;
  assign idx_wrap  = slot_wrap && (idx == LAST_IDX);

  // Scan timer: slot counter, digit index and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      if (idx_wrap)  frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Stage p0: select the current word and decide whether it is lit this cycle
  assign cur_word = words[idx];
  assign phase    = slot_cnt[SCAN_LOG2-1 -: 4];
  assign blink_ph = frame_cnt[BLINK_LOG2];
  assign lit_p0   = cur_word[EN_POS] && (phase <= bright) &&
                    !(cur_word[BLINK_POS] && blink_ph);

  seg7_glyph_decoder u_glyph (
    .code (cur_word[CODE_HI:CODE_LO]),
    .seg  (glyph_p0)
  );

  // Active-high drive values for the selected digit
  always_comb begin
    e_p0   = '0;
    seg_p0 = SEG_OFF;
    dp_p0  = 1'b0;
    if (lit_p0) begin
      e_p0   = NUM_DIGITS'(1) << idx;
      seg_p0 = glyph_p0;
      dp_p0  = cur_word[DP_POS];
    end
  end

  // Output registers with board polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      E      <= E_IDLE;
      segOut <= SEG_IDLE;
      DP     <= POL;
    end else begin
      E      <= e_p0 ^ E_IDLE;
      segOut <= seg_p0 ^ {7{POL}};
      DP     <= dp_p0 ^ POL;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: two instances (4 digits and 5 digits) driven from
// the same stimulus and compared every cycle against a time-based reference.
module tb_seg_display_mux;

  localparam int S = 4;
  localparam int B = 1;
  localparam longint SLOT = 64'd1 << S;

  logic       clk = 1'b0;
  logic       rst;
  logic       W;
  logic [1:0] wadd4;
  logic [2:0] wadd5;
  logic [6:0] DIN;
  logic [3:0] bright;
  logic [3:0] e4;
  logic [4:0] e5;
  logic [6:0] seg4, seg5;
  logic       dp4, dp5;

  int errs   = 0;
  int checks = 0;

  // Reference state: cycles since reset release and shadow word arrays
  longint     t4, t5;
  logic [6:0] w4 [4];
  logic [6:0] w5 [5];

  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seg_display_mux #(.NUM_DIGITS(4), .SCAN_LOG2(S), .BLINK_LOG2(B), .ACTIVE_LOW(1)) dut4 (
    .clk(clk), .rst(rst), .W(W), .WADD(wadd4), .DIN(DIN), .bright(bright),
    .E(e4), .segOut(seg4), .DP(dp4)
  );

  seg_display_mux #(.NUM_DIGITS(5), .SCAN_LOG2(S), .BLINK_LOG2(B), .ACTIVE_LOW(1)) dut5 (
    .clk(clk), .rst(rst), .W(W), .WADD(wadd5), .DIN(DIN), .bright(bright),
    .E(e5), .segOut(seg5), .DP(dp5)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int cur_idx(input int n, input longint t);
    return int'((t / SLOT) % n);
  endfunction

  // Expected active-low {E[15:0], seg[6:0], dp} for n digits, t cycles after reset
  function automatic logic [23:0] model_out(input int n, input longint t,
                                            input logic [6:0] w, input logic [3:0] br);
    int         idx   = cur_idx(n, t);
    int         ph    = int'((t % SLOT) >> (S - 4));
    longint     frame = t / (SLOT * n);
    bit         bph   = ((frame >> B) & 1) == 1;
    bit         lit   = w[5] && (ph <= int'(br)) && !(w[6] && bph);
    logic [15:0] e    = 16'hFFFF;
    logic [6:0]  s    = 7'h7F;
    logic        d    = 1'b1;
    if (lit) begin
      e = ~(16'd1 << idx);
      s = ~gly[w[4:1]];
      d = ~w[0];
    end
    return {e, s, d};
  endfunction

  // One clock: apply inputs, compare both instances, then advance the reference
  task automatic cycle(input bit r, input bit w, input logic [2:0] a, input logic [6:0] d);
    logic [23:0] x4, x5;
    rst = r; W = w; wadd5 = a; wadd4 = a[1:0]; DIN = d;
    if (r) begin
      x4 = 24'hFFFFFF;
      x5 = 24'hFFFFFF;
    end else begin
      x4 = model_out(4, t4, w4[cur_idx(4, t4)], bright);
      x5 = model_out(5, t5, w5[cur_idx(5, t5)], bright);
    end
    @(posedge clk);
    #1;
    chk("E4",   16'(e4),   16'(x4[11:8]));
    chk("SEG4", 16'(seg4), 16'(x4[7:1]));
    chk("DP4",  16'(dp4),  16'(x4[0]));
    chk("E5",   16'(e5),   16'(x5[12:8]));
    chk("SEG5", 16'(seg5), 16'(x5[7:1]));
    chk("DP5",  16'(dp5),  16'(x5[0]));
    if (r) begin
      t4 = 0; t5 = 0;
      for (int i = 0; i < 4; i++) w4[i] = '0;
      for (int i = 0; i < 5; i++) w5[i] = '0;
    end else begin
      if (w) w4[a[1:0]] = d;
      if (w && a < 3'd5) w5[a] = d;
      t4++; t5++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 7'd0);
  endtask

  initial begin
    rst = 1'b1; W = 1'b0; wadd4 = '0; wadd5 = '0; DIN = '0; bright = 4'd15;
    t4 = 0; t5 = 0;
    for (int i = 0; i < 4; i++) w4[i] = '0;
    for (int i = 0; i < 5; i++) w5[i] = '0;

    // Reset, then a long stretch with nothing written
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'd0, 7'd0);
    idle(200);

    // Single digit: enabled code 3 with DP at full brightness
    cycle(1'b0, 1'b1, 3'd0, 7'b0100111);
    idle(150);

    // All four digits: A, b, C, F enabled
    cycle(1'b0, 1'b1, 3'd0, {1'b0, 1'b1, 4'hA, 1'b0});
    cycle(1'b0, 1'b1, 3'd1, {1'b0, 1'b1, 4'hB, 1'b1});
    cycle(1'b0, 1'b1, 3'd2, {1'b0, 1'b1, 4'hC, 1'b0});
    cycle(1'b0, 1'b1, 3'd3, {1'b0, 1'b1, 4'hF, 1'b1});
    cycle(1'b0, 1'b1, 3'd4, {1'b0, 1'b1, 4'h8, 1'b0});
    idle(200);

    // Dim brightness
    bright = 4'd3;
    idle(200);
    bright = 4'd0;
    idle(100);
    bright = 4'd15;

    // Blink on digit 2 across several blink periods
    cycle(1'b0, 1'b1, 3'd2, {1'b1, 1'b1, 4'h7, 1'b1});
    idle(700);

    // Mid-slot write colliding with reset: reset wins
    idle(5);
    cycle(1'b1, 1'b1, 3'd2, 7'b0100111);
    idle(100);

    // Out-of-range address on the 5-digit instance
    cycle(1'b0, 1'b1, 3'd1, {1'b0, 1'b1, 4'h5, 1'b0});
    cycle(1'b0, 1'b1, 3'd5, {1'b0, 1'b1, 4'h2, 1'b1});
    cycle(1'b0, 1'b1, 3'd7, {1'b0, 1'b1, 4'h9, 1'b1});
    idle(200);

    // Randomized writes, brightness changes and occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) bright = 4'($urandom);
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)), 7'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
